// File: rtl/result_collector.sv
// Result-write receiver: launches a producer run, buffers its words in a FIFO, flags end of frame.
// Optional COLLECT_TIMEOUT_EN adds an idle watchdog that forces DONE after TIMEOUT_CYC quiet cycles.
module result_collector #(
    parameter int unsigned DATA_W      = 21,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       go,
    output logic                       w_start,
    input  logic                       wr_req,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       src_done,
    output logic                       full,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       busy,
    output logic                       frame_done,
    output logic [7:0]                 frame_words,
    output logic                       overflow,
    output logic                       timeout
);

    localparam int unsigned AW = $clog2(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("result_collector: DEPTH must be a power of 2 and >= 2");
    end
    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("result_collector: TIMEOUT_CYC must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        START   = 2'd1,
        COLLECT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              wr_acc;
    logic              rd_acc;
    logic              wd_hit;

    assign full   = (count == (AW+1)'(DEPTH));
    assign empty  = (count == '0);
    assign wr_acc = (state == COLLECT) && wr_req && !full;
    assign rd_acc = rd_en && !empty;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (go) state_nx = START;
            START:   state_nx = COLLECT;
            COLLECT: if (src_done || wd_hit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        w_start    = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            START:   begin w_start = 1'b1; busy = 1'b1; end
            COLLECT: busy = 1'b1;
            DONE:    frame_done = 1'b1;
            default: ;
        endcase
    end

    // FIFO storage holds no reset; validity is tracked by the pointers and count alone
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                rd_data <= mem[rd_ptr];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame_words <= '0;
            overflow    <= 1'b0;
        end else if (state == START) begin
            frame_words <= '0;
            overflow    <= 1'b0;
        end else begin
            if (wr_acc && frame_words != 8'hFF) frame_words <= frame_words + 1'b1;
            if (state == COLLECT && wr_req && full) overflow <= 1'b1;
        end
    end

`ifdef COLLECT_TIMEOUT_EN
    logic [7:0] idle_cnt;
    logic       timeout_q;

    assign wd_hit  = (state == COLLECT) && !wr_req && !src_done
                     && (idle_cnt == 8'(TIMEOUT_CYC - 1));
    assign timeout = timeout_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (state != COLLECT || wr_req || src_done) begin
                idle_cnt <= '0;
            end else begin
                idle_cnt <= idle_cnt + 1'b1;
            end
            if (state == START) begin
                timeout_q <= 1'b0;
            end else if (wd_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: scoreboard queue of expected FIFO words, immediate-assert checks.
module tb_result_collector;

    localparam int unsigned DATA_W = 21;
    localparam int unsigned DEPTH  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic              go;
    logic              w_start;
    logic              wr_req;
    logic [DATA_W-1:0] wr_data;
    logic              src_done;
    logic              full;
    logic              rd_en;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              empty;
    logic [4:0]        count;
    logic              busy;
    logic              frame_done;
    logic [7:0]        frame_words;
    logic              overflow;
    logic              timeout;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;
    logic [DATA_W-1:0] sb [$];

    always #5 clk = ~clk;

    result_collector #(
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .go          (go),
        .w_start     (w_start),
        .wr_req      (wr_req),
        .wr_data     (wr_data),
        .src_done    (src_done),
        .full        (full),
        .rd_en       (rd_en),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .empty       (empty),
        .count       (count),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_words (frame_words),
        .overflow    (overflow),
        .timeout     (timeout)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic start_run();
        go = 1'b1;
        tick();
        go = 1'b0;
        check("w_start_after_go", 32'(w_start), 32'd1);
        tick();
        check("w_start_one_cycle", 32'(w_start), 32'd0);
    endtask

    task automatic pop_check(input string tag);
        logic [DATA_W-1:0] exp;
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        check({tag, "_valid"}, 32'(rd_valid), 32'd1);
        check({tag, "_data"}, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        rst = 1'b0; go = 1'b0; wr_req = 1'b0; wr_data = '0; src_done = 1'b0; rd_en = 1'b0;
        tick();
        tick();
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_wstart", 32'(w_start), 32'd0);
        check("rst_words", 32'(frame_words), 32'd0);
        rst = 1'b1;
        tick();
        check("no_wstart_on_release", 32'(w_start), 32'd0);

        // Basic run
        start_run();
        for (int i = 1; i <= 4; i++) begin
            wr_req = 1'b1; wr_data = DATA_W'(i); sb.push_back(DATA_W'(i));
            tick();
        end
        wr_req = 1'b0; src_done = 1'b1;
        tick();
        src_done = 1'b0;
        check("basic_frame_done", 32'(frame_done), 32'd1);
        check("basic_words", 32'(frame_words), 32'd4);
        check("basic_busy_done", 32'(busy), 32'd0);
        tick();
        check("basic_frame_done_pulse", 32'(frame_done), 32'd0);
        check("basic_count", 32'(count), 32'd4);
        for (int i = 0; i < 4; i++) pop_check("basic_pop");
        tick();
        check("basic_rd_valid_low", 32'(rd_valid), 32'd0);
        check("basic_empty", 32'(empty), 32'd1);

        // Overflow: 18 writes into 16 entries, no reads
        start_run();
        for (int i = 0; i < 18; i++) begin
            wr_req = 1'b1; wr_data = DATA_W'(32'h100 + i);
            if (i < 16) sb.push_back(DATA_W'(32'h100 + i));
            tick();
        end
        wr_req = 1'b0;
        check("ovf_count", 32'(count), 32'd16);
        check("ovf_full", 32'(full), 32'd1);
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_words", 32'(frame_words), 32'd16);

        // Write at full with concurrent read: write dropped, read proceeds
        wr_req = 1'b1; wr_data = DATA_W'(32'h777); rd_en = 1'b1;
        tick();
        wr_req = 1'b0; rd_en = 1'b0;
        check("cc_full_count", 32'(count), 32'd15);
        check("cc_full_ovf", 32'(overflow), 32'd1);
        check("cc_full_valid", 32'(rd_valid), 32'd1);
        check("cc_full_data", 32'(rd_data), 32'(sb.pop_front()));
        for (int i = 0; i < 15; i++) pop_check("ovf_pop");
        check("ovf_drained", 32'(empty), 32'd1);

        // Read at empty with concurrent write: read ignored
        wr_req = 1'b1; wr_data = DATA_W'(32'h55); rd_en = 1'b1; sb.push_back(DATA_W'(32'h55));
        tick();
        rd_en = 1'b0;
        check("cc_empty_count", 32'(count), 32'd1);
        check("cc_empty_valid", 32'(rd_valid), 32'd0);

        // Last word together with src_done
        wr_data = DATA_W'(32'h66); src_done = 1'b1; sb.push_back(DATA_W'(32'h66));
        tick();
        wr_req = 1'b0; src_done = 1'b0;
        check("last_word_frame_done", 32'(frame_done), 32'd1);
        check("last_word_counted", 32'(frame_words), 32'd18);
        check("last_word_count", 32'(count), 32'd2);
        tick();

        // wr_req in IDLE is ignored
        wr_req = 1'b1; wr_data = DATA_W'(32'h99);
        tick();
        wr_req = 1'b0;
        check("idle_wr_count", 32'(count), 32'd2);
        check("idle_wr_no_ovf", 32'(overflow), 32'd1);
        for (int i = 0; i < 2; i++) pop_check("edge_pop");

        // go during COLLECT: no second start; flags cleared by START
        start_run();
        check("start_clears_ovf", 32'(overflow), 32'd0);
        check("start_clears_words", 32'(frame_words), 32'd0);
        go = 1'b1;
        tick();
        check("go_in_collect_no_wstart", 32'(w_start), 32'd0);
        check("go_in_collect_busy", 32'(busy), 32'd1);
        tick();
        go = 1'b0;
        check("go_in_collect_no_wstart2", 32'(w_start), 32'd0);
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        tick();

        // Watchdog
        start_run();
`ifdef COLLECT_TIMEOUT_EN
        for (int i = 0; i < 7; i++) tick();
        check("wd_still_busy", 32'(busy), 32'd1);
        tick();
        check("wd_frame_done", 32'(frame_done), 32'd1);
        check("wd_timeout", 32'(timeout), 32'd1);
        tick();
        check("wd_idle", 32'(busy), 32'd0);
`else
        for (int i = 0; i < 20; i++) tick();
        check("no_wd_busy", 32'(busy), 32'd1);
        check("no_wd_timeout", 32'(timeout), 32'd0);
        src_done = 1'b1;
        tick();
        src_done = 1'b0;
        tick();
`endif

        // Reset mid-COLLECT with 5 words buffered
        start_run();
        for (int i = 0; i < 5; i++) begin
            wr_req = 1'b1; wr_data = DATA_W'(32'h200 + i);
            tick();
        end
        wr_req = 1'b0;
        check("pre_rst_count", 32'(count), 32'd5);
        rst = 1'b0;
        #1;
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_count", 32'(count), 32'd0);
        check("async_rst_busy", 32'(busy), 32'd0);
        check("async_rst_wstart", 32'(w_start), 32'd0);
        sb.delete();
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
